// File: rtl/data_cache_if.sv
// CPU-side and memory-side bundles for the L1 data cache.
// Signal names match the cache's documented port list.
interface cache_cpu_if;
  logic        cpu_re_i;
  logic        cpu_we_i;
  logic        cpu_byte_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        stall_o;

  modport master (
    output cpu_re_i, cpu_we_i, cpu_byte_i,
    output cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, stall_o
  );

  modport slave (
    input  cpu_re_i, cpu_we_i, cpu_byte_i,
    input  cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, stall_o
  );
endinterface

interface cache_mem_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o,
    output mem_wdata_o, mem_wstrb_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o,
    input  mem_wdata_o, mem_wstrb_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// One word per line; stalls the pipeline on load misses and stores.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int SETS       = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_cpu_if.slave            cpu,
  cache_mem_if.master           mem,
  output logic [DATA_WIDTH-1:0] hit_count_o,
  output logic [DATA_WIDTH-1:0] miss_count_o
);
  localparam int IDX = $clog2(SETS);
  localparam int TW  = DATA_WIDTH - IDX - 2;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SETS-1:0]       r_valid;
  logic [TW-1:0]         r_tag  [SETS];
  logic [DATA_WIDTH-1:0] r_data [SETS];

  logic [IDX-1:0]        w_idx;
  logic [TW-1:0]         w_tag;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_line;
  logic [DATA_WIDTH-1:0] w_shr;
  logic [4:0]            w_sh;
  logic [DATA_WIDTH-1:0] w_rd;
  logic [3:0]            w_strb;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_fill;
  logic                  w_wr_upd;
  logic                  w_hit_inc;
  logic                  w_miss_inc;

  assign w_idx  = cpu.cpu_addr_i[IDX+1:2];
  assign w_tag  = cpu.cpu_addr_i[DATA_WIDTH-1:IDX+2];
  assign w_line = r_data[w_idx];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_sh   = {cpu.cpu_addr_i[1:0], 3'b000};
  assign w_shr  = w_line >> w_sh;
  assign w_rd   = cpu.cpu_byte_i ?
                  {24'h0, w_shr[7:0]} : w_line;
  assign w_strb = cpu.cpu_byte_i ?
                  (4'b0001 << cpu.cpu_addr_i[1:0]) : 4'b1111;
  assign w_wdata = cpu.cpu_byte_i ?
                   {4{cpu.cpu_wdata_i[7:0]}} : cpu.cpu_wdata_i;

  // Load data is only driven when the load actually completes.
  assign cpu.cpu_rdata_o = (cpu.cpu_re_i && !cpu.stall_o) ?
                           w_rd : '0;

  always_comb begin
    w_next          = r_state;
    cpu.stall_o     = 1'b0;
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = {cpu.cpu_addr_i[DATA_WIDTH-1:2], 2'b00};
    mem.mem_wdata_o = '0;
    mem.mem_wstrb_o = 4'b0000;
    w_fill          = 1'b0;
    w_wr_upd        = 1'b0;
    w_hit_inc       = 1'b0;
    w_miss_inc      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cpu.cpu_we_i) begin
          cpu.stall_o = 1'b1;
          w_next      = WR_REQ;
        end else if (cpu.cpu_re_i) begin
          if (w_hit) begin
            w_hit_inc = 1'b1;
          end else begin
            cpu.stall_o = 1'b1;
            w_miss_inc  = 1'b1;
            w_next      = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        cpu.stall_o   = 1'b1;
        mem.mem_req_o = 1'b1;
        if (mem.mem_ready_i) w_next = RD_WAIT;
      end
      RD_WAIT: begin
        cpu.stall_o = 1'b1;
        if (mem.mem_rvalid_i) begin
          w_fill = 1'b1;
          w_next = RESP;
        end
      end
      WR_REQ: begin
        cpu.stall_o     = 1'b1;
        mem.mem_req_o   = 1'b1;
        mem.mem_we_o    = 1'b1;
        mem.mem_wdata_o = w_wdata;
        mem.mem_wstrb_o = w_strb;
        if (mem.mem_ready_i) begin
          w_wr_upd = w_hit;
          w_next   = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (w_fill)     r_valid[w_idx] <= 1'b1;
      if (w_hit_inc)  hit_count_o    <= hit_count_o + 1'b1;
      if (w_miss_inc) miss_count_o   <= miss_count_o + 1'b1;
    end
  end

  // Tag/data arrays are never cleared; rst only blocks updates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_tag[w_idx]  <= w_tag;
        r_data[w_idx] <= mem.mem_rdata_i;
      end
      if (w_wr_upd) begin
        for (int b = 0; b < 4; b++) begin
          if (w_strb[b])
            r_data[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Randomized scoreboard bench for data_cache against a
// transparent write-through memory view plus a line-residency model.
module tb_data_cache;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_cpu_if cpu ();
  cache_mem_if mem ();
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  data_cache #(.DATA_WIDTH(32), .SETS(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (cpu.slave),
    .mem          (mem.master),
    .hit_count_o  (hit_cnt),
    .miss_count_o (miss_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [1024];
  logic [31:0] bk_mem  [1024];
  bit          m_valid [64];
  logic [29:0] m_line  [64];
  int          m_hits = 0;
  int          m_miss = 0;

  typedef struct {
    bit          is_ld;
    bit          exp_hit;
    logic [31:0] data;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;
  exp_t sb_q [$];
  wr_t  wr_q [$];

  int   lat_force = -1;
  int   rd_seen   = 0;
  int   mon_lat   = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    logic [31:0] w;
    w = 32'(a) * 32'h9E37_79B1;
    return w ^ 32'h5A5A_0F0F;
  endfunction

  task automatic access(input bit we, input bit bt,
                        input logic [31:0] a,
                        input logic [31:0] wd);
    int          k;
    int          wi;
    int          ix;
    logic [3:0]  strb;
    logic [31:0] d;
    logic [31:0] tmp;
    exp_t        e;
    wr_t         w;
    wi = int'(a[11:2]);
    ix = int'(a[7:2]);
    if (we) begin
      strb = bt ? (4'b0001 << a[1:0]) : 4'b1111;
      d    = bt ? {4{wd[7:0]}} : wd;
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[wi][8*b +: 8] = d[8*b +: 8];
      w.addr = {a[31:2], 2'b00};
      w.strb = strb;
      w.data = d;
      wr_q.push_back(w);
      e.is_ld   = 1'b0;
      e.exp_hit = 1'b0;
      e.data    = 32'h0;
    end else begin
      e.is_ld   = 1'b1;
      e.exp_hit = m_valid[ix] && (m_line[ix] == a[31:2]);
      if (e.exp_hit) m_hits++;
      else begin
        m_miss++;
        m_valid[ix] = 1'b1;
        m_line[ix]  = a[31:2];
      end
      tmp    = ref_mem[wi] >> (8 * int'(a[1:0]));
      e.data = bt ? {24'h0, tmp[7:0]} : ref_mem[wi];
    end
    sb_q.push_back(e);
    cpu.cpu_re_i    = !we;
    cpu.cpu_we_i    = we;
    cpu.cpu_byte_i  = bt;
    cpu.cpu_addr_i  = a;
    cpu.cpu_wdata_i = wd;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (cpu.stall_o && k < 200);
    if (k >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL access_timeout: addr %h still stalled", a);
    end
    @(posedge clk);
    #1;
    cpu.cpu_re_i = 1'b0;
    cpu.cpu_we_i = 1'b0;
  endtask

  // Monitor: pops one expectation per completed CPU request.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (cpu.cpu_re_i || cpu.cpu_we_i)) begin
        if (cpu.stall_o) mon_lat++;
        else if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: unexpected completion");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("kind_is_store", 32'(cpu.cpu_we_i),
                32'(!e.is_ld));
          if (e.is_ld) begin
            check("rdata", cpu.cpu_rdata_o, e.data);
            check("load_no_stall_iff_hit",
                  32'(mon_lat == 0), 32'(e.exp_hit));
          end else begin
            check("store_stalls", 32'(mon_lat > 0), 32'd1);
          end
          mon_lat = 0;
        end
      end else mon_lat = 0;
    end
  end

  // Backing memory responder.
  initial begin
    bit          rd_pend;
    int          rd_cnt;
    logic [31:0] rd_addr;
    rd_pend = 1'b0;
    rd_cnt  = 0;
    rd_addr = '0;
    mem.mem_ready_i  = 1'b0;
    mem.mem_rvalid_i = 1'b0;
    mem.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      mem.mem_ready_i  = 1'b0;
      mem.mem_rvalid_i = 1'b0;
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          mem.mem_rvalid_i = 1'b1;
          mem.mem_rdata_i  = bk_mem[rd_addr[11:2]];
          rd_pend = 1'b0;
        end else rd_cnt--;
      end else if (!rst && mem.mem_req_o &&
                   $urandom_range(0, 2) != 0) begin
        mem.mem_ready_i = 1'b1;
        check("mem_addr_align", 32'(mem.mem_addr_o[1:0]), 32'd0);
        if (mem.mem_we_o) begin
          if (wr_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_mem_write: addr %h",
                     mem.mem_addr_o);
          end else begin
            wr_t w;
            w = wr_q.pop_front();
            check("wr_addr", mem.mem_addr_o, w.addr);
            check("wr_strb", 32'(mem.mem_wstrb_o), 32'(w.strb));
            check("wr_data", mem.mem_wdata_o, w.data);
          end
          for (int b = 0; b < 4; b++)
            if (mem.mem_wstrb_o[b])
              bk_mem[mem.mem_addr_o[11:2]][8*b +: 8] =
                mem.mem_wdata_o[8*b +: 8];
        end else begin
          rd_pend = 1'b1;
          rd_addr = mem.mem_addr_o;
          rd_cnt  = (lat_force >= 0) ? lat_force :
                    int'($urandom_range(0, 3));
          rd_seen++;
        end
      end
    end
  end

  initial begin
    int k;
    int start;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = init_word(i);
      bk_mem[i]  = init_word(i);
    end
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = '0;
    end
    ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    bk_mem[32'h100 >> 2]  = 32'hDEAD_BEEF;
    rst             = 1'b1;
    cpu.cpu_re_i    = 1'b0;
    cpu.cpu_we_i    = 1'b0;
    cpu.cpu_byte_i  = 1'b0;
    cpu.cpu_addr_i  = '0;
    cpu.cpu_wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_stall", 32'(cpu.stall_o), 32'd0);
    check("rst_mem_req", 32'(mem.mem_req_o), 32'd0);
    check("rst_rdata", cpu.cpu_rdata_o, 32'd0);
    check("rst_hits", hit_cnt, 32'd0);
    check("rst_misses", miss_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    lat_force = 3;
    access(0, 0, 32'h100, 0);
    lat_force = -1;
    access(0, 0, 32'h100, 0);
    check("t1_hits", hit_cnt, 32'd1);
    check("t1_misses", miss_cnt, 32'd1);

    access(1, 1, 32'h101, 32'h0000_00AB);
    access(0, 0, 32'h100, 0);
    check("t2_line_data", ref_mem[32'h100 >> 2], 32'hDEAD_ABEF);

    access(0, 0, 32'h200, 0);
    access(0, 0, 32'h100, 0);
    check("t3_misses", miss_cnt, 32'd3);

    access(1, 0, 32'h400, 32'h55);
    access(0, 0, 32'h400, 0);
    check("t4_misses", miss_cnt, 32'd4);

    access(1, 0, 32'h100, 32'h1234_5678);
    access(0, 0, 32'h100, 0);
    access(0, 1, 32'h103, 0);
    access(0, 1, 32'h100, 0);
    check("t5_hits", hit_cnt, 32'd4);

    // Abort a read in RD_WAIT; both lines must be gone afterwards.
    lat_force = 4;
    cpu.cpu_re_i   = 1'b1;
    cpu.cpu_byte_i = 1'b0;
    cpu.cpu_addr_i = 32'h304;
    start = rd_seen;
    k = 0;
    while (rd_seen == start && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst_read_issued", 32'(rd_seen != start), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu.cpu_re_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem_req", 32'(mem.mem_req_o), 32'd0);
    check("abort_stall", 32'(cpu.stall_o), 32'd0);
    check("abort_hits", hit_cnt, 32'd0);
    check("abort_misses", miss_cnt, 32'd0);
    repeat (8) @(posedge clk);
    #1;
    lat_force = -1;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_miss = 0;
    access(0, 0, 32'h100, 0);
    access(0, 0, 32'h304, 0);
    check("t6_misses", miss_cnt, 32'd2);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      bit          we;
      bit          bt;
      a  = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) == 0) a = a & 32'h0000_00FF;
      we = ($urandom_range(0, 9) < 3);
      bt = $urandom_range(0, 1) == 1;
      access(we, bt, a, $urandom);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    check("final_hits", hit_cnt, 32'(m_hits));
    check("final_misses", miss_cnt, 32'(m_miss));
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("wr_drained", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
